// File: rtl/battleship_pkg.sv
// rtl/battleship_pkg.sv - shared cell encoding, grid size and FSM states for the game controller
package battleship_pkg;

    localparam int GRID_N = 9;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        SHIP  = 2'b01,
        MISS  = 2'b10,
        HIT   = 2'b11
    } cell_t;

    typedef enum logic [1:0] {
        PLACE = 2'b00,
        FIRE  = 2'b01,
        BLANK = 2'b10,
        OVER  = 2'b11
    } state_t;

endpackage

// File: rtl/bs_cursor.sv
// rtl/bs_cursor.sv - wrapping 9x9 cursor; opposing moves on one axis cancel
module bs_cursor
    import battleship_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    output logic [3:0] row,
    output logic [3:0] col
);

    function automatic logic [3:0] step(input logic [3:0] v, input logic dec, input logic inc);
        if (inc && !dec) return (v == 4'(GRID_N - 1)) ? 4'd0 : v + 4'd1;
        if (dec && !inc) return (v == 4'd0) ? 4'(GRID_N - 1) : v - 4'd1;
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            row <= 4'd0;
            col <= 4'd0;
        end else if (en) begin
            row <= step(row, up, down);
            col <= step(col, left, right);
        end
    end

endmodule

// File: rtl/game_controller.sv
// rtl/game_controller.sv - battleship turn FSM (place/fire/blank/over); GC_BLANK_SKIP_EN lets confirm end the blank screen
module game_controller
    import battleship_pkg::*;
#(
    parameter int SHIP_CELLS   = 5,
    parameter int BLANK_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_confirm,
    input  logic [1:0] query_state,
    output logic [3:0] sel_row,
    output logic [3:0] sel_col,
    output logic       place_pulse,
    output logic       fire_pulse,
    output logic       placing_phase,
    output logic       active_player,
    output logic       player_view,
    output logic       show_blank,
    output logic       query_player,
    output logic       game_over,
    output logic       winner,
    output logic [3:0] p1_hits,
    output logic [3:0] p2_hits
);

    state_t      state;
    logic [3:0]  placed_cnt;
    logic [31:0] blank_cnt;
    logic        blank_from_place;
    logic        confirm_ok;
    logic        confirm_accept;
    logic        blank_done;
    logic [3:0]  hits_active;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= 4'(SHIP_CELLS)) ? v : v + 4'd1;
    endfunction

    always_comb begin
        confirm_ok = 1'b0;
        if (state == PLACE)
            confirm_ok = (query_state == EMPTY);
        else if (state == FIRE)
            confirm_ok = (query_state == EMPTY) || (query_state == SHIP);
    end

    // The grid is not updated until the pulse cycle ends, so confirm is locked out during it.
    assign confirm_accept = btn_confirm && confirm_ok && !place_pulse && !fire_pulse;
    assign hits_active    = active_player ? p2_hits : p1_hits;

`ifdef GC_BLANK_SKIP_EN
    assign blank_done = (blank_cnt == 32'(BLANK_CYCLES - 1)) || btn_confirm;
`else
    assign blank_done = (blank_cnt == 32'(BLANK_CYCLES - 1));
`endif

    bs_cursor u_cursor (
        .clk   (clk),
        .reset (reset),
        .en    ((state == PLACE || state == FIRE) && !confirm_accept),
        .up    (btn_up),
        .down  (btn_down),
        .left  (btn_left),
        .right (btn_right),
        .row   (sel_row),
        .col   (sel_col)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= PLACE;
            active_player    <= 1'b0;
            placed_cnt       <= 4'd0;
            blank_cnt        <= 32'd0;
            blank_from_place <= 1'b0;
            p1_hits          <= 4'd0;
            p2_hits          <= 4'd0;
            place_pulse      <= 1'b0;
            fire_pulse       <= 1'b0;
            placing_phase    <= 1'b1;
            player_view      <= 1'b0;
            query_player     <= 1'b0;
            show_blank       <= 1'b0;
            game_over        <= 1'b0;
            winner           <= 1'b0;
        end else begin
            place_pulse <= 1'b0;
            fire_pulse  <= 1'b0;
            case (state)
                PLACE: begin
                    if (place_pulse && placed_cnt == 4'(SHIP_CELLS)) begin
                        placed_cnt       <= 4'd0;
                        blank_from_place <= 1'b1;
                        blank_cnt        <= 32'd0;
                        show_blank       <= 1'b1;
                        placing_phase    <= 1'b0;
                        state            <= BLANK;
                    end else if (confirm_accept) begin
                        place_pulse <= 1'b1;
                        placed_cnt  <= placed_cnt + 4'd1;
                    end
                end
                FIRE: begin
                    if (fire_pulse) begin
                        if (hits_active == 4'(SHIP_CELLS)) begin
                            game_over   <= 1'b1;
                            winner      <= active_player;
                            player_view <= ~active_player;
                            state       <= OVER;
                        end else begin
                            blank_from_place <= 1'b0;
                            blank_cnt        <= 32'd0;
                            show_blank       <= 1'b1;
                            state            <= BLANK;
                        end
                    end else if (confirm_accept) begin
                        fire_pulse <= 1'b1;
                        if (query_state == SHIP) begin
                            if (active_player) p2_hits <= sat_inc(p2_hits);
                            else               p1_hits <= sat_inc(p1_hits);
                        end
                    end
                end
                BLANK: begin
                    if (blank_done) begin
                        show_blank <= 1'b0;
                        if (blank_from_place && !active_player) begin
                            active_player <= 1'b1;
                            placing_phase <= 1'b1;
                            player_view   <= 1'b1;
                            query_player  <= 1'b1;
                            state         <= PLACE;
                        end else begin
                            // Every other exit hands the turn to the other player for firing.
                            active_player <= ~active_player;
                            placing_phase <= 1'b0;
                            player_view   <= active_player;
                            query_player  <= active_player;
                            state         <= FIRE;
                        end
                    end else begin
                        blank_cnt <= blank_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_game_controller.sv
// tb/tb_game_controller.sv - directed game scenario checked against a turn-level model every cycle
module tb_game_controller;

    localparam int SC = 5;
    localparam int BC = 40;
    localparam logic [4:0] UP = 5'b10000, DN = 5'b01000, LF = 5'b00100, RT = 5'b00010, CF = 5'b00001;

    logic clk = 1'b0, reset = 1'b1;
    logic btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, btn_confirm = 0;
    logic [1:0] query_state;
    logic [3:0] sel_row, sel_col, p1_hits, p2_hits;
    logic place_pulse, fire_pulse, placing_phase, active_player, player_view;
    logic show_blank, query_player, game_over, winner;

    game_controller #(.SHIP_CELLS(SC), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_confirm(btn_confirm), .query_state(query_state),
        .sel_row(sel_row), .sel_col(sel_col), .place_pulse(place_pulse), .fire_pulse(fire_pulse),
        .placing_phase(placing_phase), .active_player(active_player), .player_view(player_view),
        .show_blank(show_blank), .query_player(query_player), .game_over(game_over),
        .winner(winner), .p1_hits(p1_hits), .p2_hits(p2_hits)
    );

    always #5 clk = ~clk;

    // Board datapath stand-in, written by the DUT's own strobes.
    logic [1:0] env_b [2][9][9];
    assign query_state = env_b[query_player][sel_row][sel_col];

    always @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < 2; p++)
                for (int r = 0; r < 9; r++)
                    for (int c = 0; c < 9; c++) env_b[p][r][c] <= 2'b00;
        end else if (place_pulse) begin
            env_b[query_player][sel_row][sel_col] <= 2'b01;
        end else if (fire_pulse) begin
            env_b[query_player][sel_row][sel_col] <= (query_state == 2'b01) ? 2'b11 : 2'b10;
        end
    end

    int checks = 0, errors = 0;
    int n_place = 0, n_fire = 0, n_blank = 0;
    bit started = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            if (place_pulse) n_place++;
            if (fire_pulse) n_fire++;
            if (show_blank) n_blank++;
        end
    end

    // Model: phase 0 place, 1 fire, 2 blank, 3 over.
    int m_st, m_ap, m_row, m_col, m_placed, m_left, m_from_place, m_winner, m_pp, m_fp;
    int m_hits [2];
    int m_board [2][9][9];

    always @(posedge clk) begin : model_step
        int q, acc, np, nf, moving, opp;
        if (reset) begin
            m_st = 0; m_ap = 0; m_row = 0; m_col = 0; m_placed = 0; m_left = 0;
            m_from_place = 0; m_winner = 0; m_pp = 0; m_fp = 0; m_hits[0] = 0; m_hits[1] = 0;
            for (int p = 0; p < 2; p++)
                for (int r = 0; r < 9; r++)
                    for (int c = 0; c < 9; c++) m_board[p][r][c] = 0;
            started = 1;
        end else begin
            acc = 0; np = 0; nf = 0;
            opp = 1 - m_ap;
            moving = (m_st == 0 || m_st == 1);
            q = m_board[(m_st == 1) ? opp : m_ap][m_row][m_col];
            case (m_st)
                0: if (m_pp && m_placed == SC) begin
                       m_placed = 0; m_from_place = 1; m_left = BC; m_st = 2;
                   end else if (btn_confirm && !m_pp && q == 0) begin
                       acc = 1; np = 1; m_placed++; m_board[m_ap][m_row][m_col] = 1;
                   end
                1: if (m_fp) begin
                       if (m_hits[m_ap] == SC) begin m_st = 3; m_winner = m_ap; end
                       else begin m_st = 2; m_from_place = 0; m_left = BC; end
                   end else if (btn_confirm && q <= 1) begin
                       acc = 1; nf = 1;
                       if (q == 1 && m_hits[m_ap] < SC) m_hits[m_ap]++;
                       m_board[opp][m_row][m_col] = (q == 1) ? 3 : 2;
                   end
                2: begin
`ifdef GC_BLANK_SKIP_EN
                       if (m_left == 1 || btn_confirm) begin
`else
                       if (m_left == 1) begin
`endif
                           if (m_from_place && m_ap == 0) begin m_st = 0; m_ap = 1; end
                           else begin m_st = 1; m_ap = opp; end
                       end else m_left--;
                   end
                default: ;
            endcase
            if (moving && !acc) begin
                m_row = (m_row + int'(btn_down) - int'(btn_up) + 9) % 9;
                m_col = (m_col + int'(btn_right) - int'(btn_left) + 9) % 9;
            end
            m_pp = np; m_fp = nf;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("sel_row", sel_row, m_row);
            chk("sel_col", sel_col, m_col);
            chk("place_pulse", place_pulse, m_pp);
            chk("fire_pulse", fire_pulse, m_fp);
            chk("placing_phase", placing_phase, int'(m_st == 0));
            chk("show_blank", show_blank, int'(m_st == 2));
            chk("game_over", game_over, int'(m_st == 3));
            chk("active_player", active_player, m_ap);
            chk("winner", winner, m_winner);
            chk("p1_hits", p1_hits, m_hits[0]);
            chk("p2_hits", p2_hits, m_hits[1]);
            if (m_st != 2)
                chk("player_view", player_view, (m_st == 0) ? m_ap : (m_st == 1) ? 1 - m_ap : 1 - m_winner);
            if (m_st < 2)
                chk("query_player", query_player, (m_st == 0) ? m_ap : 1 - m_ap);
        end
    end

    task automatic cyc(input logic [4:0] b);
        {btn_up, btn_down, btn_left, btn_right, btn_confirm} = b;
        @(negedge clk);
        {btn_up, btn_down, btn_left, btn_right, btn_confirm} = 5'b0;
    endtask

    task automatic move_to(input int r, input int c);
        for (int i = 0; i < 9 && m_row != r; i++) cyc(DN);
        for (int i = 0; i < 9 && m_col != c; i++) cyc(RT);
    endtask

    task automatic wait_play();
        for (int i = 0; i < BC + 10 && m_st == 2; i++) cyc(5'b0);
        if (m_st == 2) chk("blank_timeout", 1, 0);
    endtask

    int pr [5] = '{1, 2, 4, 6, 8};
    int pc [5] = '{1, 3, 4, 7, 0};
    int base, fbase;

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_row", sel_row, 0);
        chk("rst_col", sel_col, 0);
        chk("rst_placing", placing_phase, 1);
        chk("rst_pulses", int'(place_pulse | fire_pulse), 0);

        cyc(LF);
        chk("wrap_left", sel_col, 8);
        cyc(UP | RT);
        chk("wrap_up_row", sel_row, 8);
        chk("wrap_right_col", sel_col, 0);
        cyc(UP | DN);
        chk("cancel_row", sel_row, 8);
        cyc(LF | RT | DN);
        chk("cancel_col", sel_col, 0);
        chk("down_wrap_row", sel_row, 0);

        base = n_place;
        for (int i = 0; i < 5; i++) begin
            move_to(pr[i], pc[i]);
            cyc(i == 2 ? (CF | DN) : CF);
            cyc(5'b0);
            if (i == 1) begin
                cyc(CF);
                cyc(5'b0);
                chk("dup_place_ignored", n_place - base, 2);
            end
            if (i == 2) chk("move_dropped_on_confirm", sel_row, 4);
        end
        chk("p0_place_pulses", n_place - base, 5);
        chk("blank_after_place", show_blank, 1);
        base = n_blank;
        wait_play();
        chk("blank_length", n_blank - base, BC);
        chk("p1_place_turn", active_player, 1);
        chk("p1_placing", placing_phase, 1);

        for (int i = 0; i < 5; i++) begin
            move_to(pr[i], pc[i]);
            cyc(CF);
            cyc(5'b0);
        end
        wait_play();
        chk("fire_turn_p0", active_player, 0);
        chk("fire_phase", placing_phase, 0);

        for (int k = 0; k < 5; k++) begin
            move_to(pr[k], pc[k]);
            if (k == 0) begin
                fbase = n_fire;
                cyc(CF);
                cyc(CF);
                chk("back_to_back_fire", n_fire - fbase, 1);
            end else begin
                cyc(CF);
                cyc(5'b0);
            end
            if (k == 4) break;
            wait_play();
            if (k == 1) begin
                move_to(0, 0);
                fbase = n_fire;
                cyc(CF);
                cyc(5'b0);
                chk("miss_refire_ignored", n_fire - fbase, 0);
                chk("miss_no_turn_change", active_player, 1);
            end
            move_to(0, k);
            cyc(CF);
            cyc(5'b0);
            wait_play();
        end
        chk("win_p1_hits", p1_hits, 5);
        chk("win_game_over", game_over, 1);
        chk("win_winner", winner, 0);
        chk("win_view", player_view, 1);
        fbase = n_fire;
        cyc(CF | UP | LF);
        cyc(DN);
        repeat (3) cyc(CF);
        chk("over_row_frozen", sel_row, 8);
        chk("over_col_frozen", sel_col, 0);
        chk("over_no_fire", n_fire - fbase, 0);
        chk("over_sticky", game_over, 1);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            move_to(pr[i], pc[i]);
            cyc(CF);
            cyc(5'b0);
        end
        chk("blank_again", show_blank, 1);
        repeat (37) cyc(5'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midblank_rst_blank", show_blank, 0);
        chk("midblank_rst_placing", placing_phase, 1);
        chk("midblank_rst_row", sel_row, 0);
        chk("midblank_rst_col", sel_col, 0);
        chk("midblank_rst_hits", int'(p1_hits) + int'(p2_hits), 0);
        chk("midblank_rst_pulse", int'(place_pulse | fire_pulse), 0);
        repeat (3) cyc(5'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 SHALL have parameter SHIP_CELLS, default 5, number of ship cells each player places; hits needed to win.
REQ-002 SHALL have parameter BLANK_CYCLES, default 100_000_000, blank-screen duration in clk cycles, legal range 2 or more.
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have ports btn_up, btn_down, btn_left, btn_right, btn_confirm, input, 1 each, debounced single-cycle pulses.
REQ-006 SHALL have port query_state, input, 2, combinational cell state at (sel_row, sel_col) of the board named by query_player.
REQ-007 SHALL have ports sel_row and sel_col, output, 4 each, cursor coordinate 0..8.
REQ-008 SHALL have ports place_pulse and fire_pulse, output, 1 each, one-cycle write strobes to the board datapath.
REQ-009 SHALL have ports placing_phase, active_player, player_view, show_blank and query_player, output, 1 each, board-datapath control.
REQ-010 SHALL have ports game_over and winner, output, 1 each, plus p1_hits and p2_hits, output, 4 each, hits scored by each player.

Function
REQ-011 SHALL implement FSM states PLACE, FIRE, BLANK, OVER; all outputs registered.
REQ-012 PLACE: placing_phase=1; player_view=query_player=active_player.
REQ-013 PLACE: btn_confirm with query_state==EMPTY SHALL assert place_pulse next cycle and increment placed_cnt; a confirm on any non-EMPTY cell SHALL be ignored.
REQ-014 PLACE: when placed_cnt reaches SHIP_CELLS, SHALL clear placed_cnt and enter BLANK in the cycle after the last place_pulse.
REQ-015 FIRE: placing_phase=0; player_view=query_player=~active_player.
REQ-016 FIRE: btn_confirm with query_state EMPTY or SHIP SHALL assert fire_pulse next cycle; a confirm on MISS or HIT SHALL be ignored with no turn change.
REQ-017 FIRE: a confirm on SHIP SHALL increment the active player's hit counter in the same cycle that fire_pulse asserts.
REQ-018 FIRE: if that hit count equals SHIP_CELLS, SHALL enter OVER next cycle with winner=active_player; otherwise SHALL enter BLANK.
REQ-019 BLANK: show_blank=1 and counter runs for BLANK_CYCLES cycles; buttons ignored except as in REQ-032.
REQ-020 BLANK exit when the placement that preceded it was player 0's: SHALL go to PLACE with active_player=1.
REQ-021 BLANK exit when the placement that preceded it was player 1's: SHALL go to FIRE with active_player=0.
REQ-022 BLANK exit after FIRE: SHALL go to FIRE with active_player toggled.
REQ-023 OVER: game_over=1, show_blank=0, player_view=~winner; all buttons ignored until reset.
REQ-024 SHALL ignore btn_confirm in any cycle where place_pulse or fire_pulse is high (one-cycle lockout until the grid updates).
REQ-025 Cursor: up/down SHALL change sel_row by -1/+1; left/right SHALL change sel_col by -1/+1. Active in PLACE and FIRE only.
REQ-026 Cursor: opposing buttons in the same cycle SHALL cancel on that axis; a move in the same cycle as an accepted confirm SHALL be dropped.
REQ-027 Cursor: sel_row and sel_col SHALL never leave 0..8.
REQ-028 Hit counters SHALL saturate at SHIP_CELLS.

Reset
REQ-029 Reset SHALL force state PLACE, active_player=0, sel=(0,0), and clear placed_cnt, blank counter and hit counters.
REQ-030 Reset SHALL drive all pulses, show_blank, game_over and winner to 0, and placing_phase to 1.
REQ-031 Reset SHALL take precedence over every event, mid-BLANK and mid-pulse included; no pulse SHALL appear in the cycle after reset.

Configuration
REQ-032 Macro GC_BLANK_SKIP_EN: when defined, btn_confirm in BLANK SHALL end BLANK next cycle, as if the count had expired.
REQ-033 Without GC_BLANK_SKIP_EN, BLANK SHALL always last exactly BLANK_CYCLES cycles.
REQ-034 Under either setting, cursor wrap SHALL hold: 8+1 gives 0 and 0-1 gives 8 on both axes.

Structure
REQ-035 Package battleship_pkg SHALL hold the cell encoding (EMPTY=00, SHIP=01, MISS=10, HIT=11), GRID_N=9, and the FSM state typedef.
REQ-036 Cursor logic SHALL be one sub-module, bs_cursor (move pulses and enable in, wrapped row/col out).

Verification
REQ-037 Place: P0 places 5 distinct cells -> exactly 5 place_pulse, then BLANK, then PLACE with active_player=1.
REQ-038 Duplicate place: confirm at (2,3) with query_state=SHIP -> no place_pulse, placed_cnt unchanged.
REQ-039 Back-to-back confirm in cycles t and t+1 -> exactly one fire_pulse, at t+1.
REQ-040 Cursor: sel=(0,8), btn_up+btn_right -> (8,0); btn_up+btn_down together -> row unchanged.
REQ-041 Win: P0 lands 5th hit -> p1_hits=5, OVER, game_over=1, winner=0, player_view=1; later buttons have no effect.
REQ-042 Reset asserted at BLANK count 37 -> next cycle PLACE, sel=(0,0), show_blank=0, hit counters 0.
